// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction word at a time, holds it
// for the controller/datapath, and picks the next address from the
// sequential, branch or jump path on the consume handshake.
// The fetch sequencer has three states: FETCH, HOLD and HALT.
// Optional build macro FETCH_PERF_EN adds the fetch_count and stall_cycles
// saturating performance counters as extra output ports.
module fetch_unit #(
  parameter int          n        = 16,
  parameter logic [n-1:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [n-1:0] imem_rdata,
  output logic [n-1:0] instr,
  output logic [2:0]   op,
  output logic [2:0]   funct,
  output logic [n-1:0] pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         jump,
  input  logic         pcsrc,
`ifdef FETCH_PERF_EN
  output logic [n-1:0] fetch_count,
  output logic [n-1:0] stall_cycles,
`endif
  output logic         halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t       state;
  logic [n-1:0] pc_next_reg;
  logic [n-1:0] pcplus2;
  logic [n-1:0] branch_off;
  logic [n-1:0] target;
  logic         is_halt;

  // Request and valid are gated by reset so nothing is offered while reset
  // is held, even though the state register already reads FETCH.
  assign imem_req    = (state == FETCH) && !reset;
  assign instr_valid = (state == HOLD) && !reset;
  assign imem_addr   = pc_next_reg;
  assign op          = instr[15:13];
  assign funct       = instr[2:0];
  assign is_halt     = (op == 3'b111) && (funct == 3'b111);

  // Address arithmetic wraps naturally at n bits.
  assign pcplus2    = pc + n'(2);
  assign branch_off = {{(n-8){instr[6]}}, instr[6:0], 1'b0};

  // Next-address select: jump has priority over a taken branch.
  always_comb begin
    // NOTE: default assignment first so every path writes target and no latch is inferred.
    target = pcplus2;
    if (jump) begin
      target = {pcplus2[n-1:13], instr[12:0]};
    end else if (pcsrc) begin
      target = pcplus2 + branch_off;
    end
  end

  // Fetch sequencer: latch the word on ack, release it on the handshake.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= FETCH;
      pc_next_reg <= RESET_PC;
      instr       <= '0;
      pc          <= RESET_PC;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            pc    <= pc_next_reg;
            state <= HOLD;
          end
        end
        HOLD: begin
          // jump/pcsrc only matter here, on the consume handshake.
          if (instr_ready) begin
            pc_next_reg <= target;
            if (is_halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters: accepted fetches and FETCH cycles spent waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count  <= '0;
      stall_cycles <= '0;
    end else if (state == FETCH) begin
      if (imem_ack) begin
        if (~&fetch_count) fetch_count <= fetch_count + n'(1);
      end else begin
        if (~&stall_cycles) stall_cycles <= stall_cycles + n'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic, all compared against a transaction-level model of the fetch rules.
module tb_fetch_unit;

  localparam int N = 16;
  localparam int M_FETCH = 0;
  localparam int M_HOLD  = 1;
  localparam int M_HALT  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ack;
  logic [N-1:0] imem_rdata;
  logic [N-1:0] instr;
  logic [2:0]   op;
  logic [2:0]   funct;
  logic [N-1:0] pc;
  logic         instr_valid;
  logic         instr_ready;
  logic         jump;
  logic         pcsrc;
  logic         halted;
`ifdef FETCH_PERF_EN
  logic [N-1:0] fetch_count;
  logic [N-1:0] stall_cycles;
`endif

  fetch_unit #(.n(N), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .pcsrc       (pcsrc),
`ifdef FETCH_PERF_EN
    .fetch_count (fetch_count),
    .stall_cycles(stall_cycles),
`endif
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state (what the unit should hold after the last edge).
  int m_st;
  int m_next;
  int m_instr;
  int m_pc;
  int m_halt;
  int m_fc;
  int m_sc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_FETCH; m_next = 0; m_instr = 0; m_pc = 0; m_halt = 0; m_fc = 0; m_sc = 0;
  endtask

  // Next fetch address from the held instruction, by plain integer arithmetic.
  function automatic int next_addr(input int j, input int p);
    int ppc, imm;
    ppc = (m_pc + 2) % 65536;
    if (j != 0) return (ppc & 'hE000) | (m_instr & 'h1FFF);
    if (p != 0) begin
      imm = m_instr & 'h7F;
      if (imm >= 64) imm -= 128;
      return (ppc + 2 * imm) & 'hFFFF;
    end
    return ppc;
  endfunction

  // One clock cycle: apply inputs, compare outputs, advance the model.
  // Called at a falling edge; returns at the next falling edge.
  task automatic cyc(input bit r, input bit a, input logic [15:0] d,
                     input bit rdy, input bit j, input bit p);
    reset = r; imem_ack = a; imem_rdata = d; instr_ready = rdy; jump = j; pcsrc = p;
    #1;
    check("imem_req",    imem_req,    (!r && m_st == M_FETCH));
    check("instr_valid", instr_valid, (!r && m_st == M_HOLD));
    check("halted",      halted,      m_halt);
    check("imem_addr",   imem_addr,   m_next);
    check("instr",       instr,       m_instr);
    check("pc",          pc,          m_pc);
    check("op",          op,          (m_instr >> 13) & 7);
    check("funct",       funct,       m_instr & 7);
`ifdef FETCH_PERF_EN
    check("fetch_count",  fetch_count,  m_fc);
    check("stall_cycles", stall_cycles, m_sc);
`endif
    if (r) begin
      model_reset();
    end else if (m_st == M_FETCH) begin
      if (a) begin
        m_instr = d; m_pc = m_next; m_st = M_HOLD;
        if (m_fc < 'hFFFF) m_fc++;
      end else begin
        if (m_sc < 'hFFFF) m_sc++;
      end
    end else if (m_st == M_HOLD && rdy) begin
      m_next = next_addr(j, p);
      if (((m_instr >> 13) & 7) == 7 && (m_instr & 7) == 7) begin
        m_st = M_HALT; m_halt = 1;
      end else begin
        m_st = M_FETCH;
      end
    end
    @(negedge clk);
  endtask

  // Walk the fetch address to an arbitrary target: +128 branch hops until
  // the upper 3 bits match, then one jump. Starts and ends in FETCH.
  task automatic goto_addr(input logic [15:0] target);
    int hops = 0;
    while (((((m_next + 2) & 'hFFFF) >> 13) != (target >> 13)) && hops < 700) begin
      cyc(0, 1, 16'h003F, 0, 0, 0);
      cyc(0, 0, 16'h0000, 1, 0, 1);
      hops++;
    end
    check("goto_bound", (hops < 700), 1);
    cyc(0, 1, {3'b000, target[12:0]}, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 1, 0);
  endtask

  initial begin
    logic [15:0] rd;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0; jump = 1'b0; pcsrc = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    cyc(1, 1, 16'hBEEF, 1, 0, 0);

    // Back-to-back fetches of 16'h2005 with zero wait states.
    cyc(0, 1, 16'h2005, 0, 0, 0);
    check("d036_valid", instr_valid, 1);
    check("d036_op", op, 3'b001);
    check("d036_funct", funct, 3'b101);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    check("d036_addr2", imem_addr, 16'h0002);
    cyc(0, 1, 16'h2005, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    check("d036_addr4", imem_addr, 16'h0004);

    // Three wait states at address 4; ready/jump noise must be ignored.
    cyc(0, 0, 16'hFFFF, 1, 1, 1);
    cyc(0, 0, 16'hFFFF, 1, 0, 1);
    cyc(0, 0, 16'hFFFF, 1, 1, 0);
    check("d037_addr", imem_addr, 16'h0004);
    check("d037_valid", instr_valid, 0);
`ifdef FETCH_PERF_EN
    check("d037_stall", stall_cycles, 3);
`endif
    cyc(0, 1, 16'h2005, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);

    // Backward branch from 0x0010, first with ready low (no redirect).
    goto_addr(16'h0010);
    cyc(0, 1, 16'h207E, 0, 0, 0);
    cyc(0, 0, 16'h0000, 0, 0, 1);
    check("d038_hold_pc", pc, 16'h0010);
    check("d038_hold_instr", instr, 16'h207E);
    check("d038_hold_valid", instr_valid, 1);
    cyc(0, 0, 16'h0000, 1, 0, 1);
    check("d038_target", imem_addr, 16'h000E);

    // Jump and branch together at 0x4020: jump wins.
    goto_addr(16'h4020);
    cyc(0, 1, 16'h0100, 0, 0, 0);
    check("d039_pc", pc, 16'h4020);
    cyc(0, 0, 16'h0000, 1, 1, 1);
    check("d039_target", imem_addr, 16'h4100);

    // Sequential wrap from the top of the address space.
    goto_addr(16'hFFFE);
    cyc(0, 1, 16'h0000, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    check("wrap_addr", imem_addr, 16'h0000);

    // HALT instruction stops fetching; acks afterwards change nothing.
    cyc(0, 1, 16'hE007, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    check("d040_halted", halted, 1);
    check("d040_req", imem_req, 0);
    cyc(0, 1, 16'h1111, 1, 1, 1);
    cyc(0, 1, 16'h2222, 1, 0, 1);
    check("d040_still_halted", halted, 1);
    check("d040_still_noreq", imem_req, 0);

    // Reset mid-FETCH with a coincident ack: the ack is dropped.
    cyc(1, 0, 16'h0000, 0, 0, 0);
    cyc(0, 0, 16'h0000, 0, 0, 0);
    cyc(1, 1, 16'h1234, 0, 0, 0);
    cyc(0, 0, 16'h0000, 0, 0, 0);
    check("d040_rst_addr", imem_addr, 16'h0000);
    check("d040_rst_instr", instr, 16'h0000);
    check("d040_rst_valid", instr_valid, 0);
    cyc(0, 1, 16'h4444, 0, 0, 0);
    check("d040_refetch_pc", pc, 16'h0000);
    check("d040_refetch_instr", instr, 16'h4444);

    // Randomized traffic with occasional resets (also recovers from HALT).
    for (int i = 0; i < 3000; i++) begin
      rd = 16'($urandom);
      cyc(($urandom % 64) == 0, $urandom % 2, rd, $urandom % 2, $urandom % 2, $urandom % 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
